// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: executes HI/LO-class operations with a
// fixed multi-cycle latency reported through Busy.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUControl,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] count, next_count;
    logic             busy_reg, next_busy;
    logic [31:0]      hi_reg, next_hi;
    logic [31:0]      lo_reg, next_lo;
    logic [31:0]      pend_hi, next_pend_hi;
    logic [31:0]      pend_lo, next_pend_lo;

    logic [63:0]      acc;
    logic [63:0]      prod_signed;
    logic [63:0]      prod_unsigned;
    logic [31:0]      divisor_safe;
    logic [31:0]      abs_a;
    logic [31:0]      abs_b;
    logic [31:0]      quot_mag;
    logic [31:0]      rem_mag;
    logic [31:0]      quot_signed;
    logic [31:0]      rem_signed;
    logic [31:0]      quot_unsigned;
    logic [31:0]      rem_unsigned;
    logic [63:0]      pending;
    logic             is_md_op;
    logic [CNT_W-1:0] load_count;

    // Signed division goes through magnitudes so that 0x80000000 / -1 wraps
    // cleanly instead of relying on the simulator's overflow behaviour.
    always_comb begin
        acc           = {hi_reg, lo_reg};
        prod_unsigned = {32'd0, A} * {32'd0, B};
        prod_signed   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        divisor_safe  = (B == 32'd0) ? 32'd1 : B;
        abs_a         = A[31] ? (32'd0 - A) : A;
        abs_b         = B[31] ? (32'd0 - B) : ((B == 32'd0) ? 32'd1 : B);
        quot_mag      = abs_a / abs_b;
        rem_mag       = abs_a % abs_b;
        quot_signed   = (A[31] ^ B[31]) ? (32'd0 - quot_mag) : quot_mag;
        rem_signed    = A[31] ? (32'd0 - rem_mag) : rem_mag;
        quot_unsigned = A / divisor_safe;
        rem_unsigned  = A % divisor_safe;
    end

    // Result that will be committed at the end of the busy window, taken from
    // the operands and HI/LO as they stand at the Start edge.
    always_comb begin
        pending    = acc;
        is_md_op   = 1'b1;
        load_count = CNT_W'(MULT_CYCLES);
        case (MDUControl)
            OP_MULT:  pending = prod_signed;
            OP_MULTU: pending = prod_unsigned;
            OP_MADD:  pending = acc + prod_signed;
            OP_MADDU: pending = acc + prod_unsigned;
            OP_MSUB:  pending = acc - prod_signed;
            OP_MSUBU: pending = acc - prod_unsigned;
            OP_DIV: begin
                load_count = CNT_W'(DIV_CYCLES);
                if (B != 32'd0) pending = {rem_signed, quot_signed};
            end
            OP_DIVU: begin
                load_count = CNT_W'(DIV_CYCLES);
                if (B != 32'd0) pending = {rem_unsigned, quot_unsigned};
            end
            default:  is_md_op = 1'b0;
        endcase
    end

    always_comb begin
        next_state   = state;
        next_count   = count;
        next_busy    = busy_reg;
        next_hi      = hi_reg;
        next_lo      = lo_reg;
        next_pend_hi = pend_hi;
        next_pend_lo = pend_lo;
        case (state)
            IDLE: begin
                if (Start && is_md_op) begin
                    next_state   = RUN;
                    next_busy    = 1'b1;
                    next_count   = load_count;
                    next_pend_hi = pending[63:32];
                    next_pend_lo = pending[31:0];
                end else if (MDUControl == OP_MTHI) begin
                    next_hi = A;
                end else if (MDUControl == OP_MTLO) begin
                    next_lo = A;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    next_state = IDLE;
                    next_busy  = 1'b0;
                    next_count = '0;
                    next_hi    = pend_hi;
                    next_lo    = pend_lo;
                end else begin
                    next_count = count - CNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            busy_reg <= 1'b0;
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            busy_reg <= next_busy;
            hi_reg   <= next_hi;
            lo_reg   <= next_lo;
            pend_hi  <= next_pend_hi;
            pend_lo  <= next_pend_lo;
        end
    end

    always_comb begin
        MDOut = 32'd0;
        if (MDUControl == OP_MFHI) MDOut = hi_reg;
        else if (MDUControl == OP_MFLO) MDOut = lo_reg;
        else if (MDUControl == OP_NONE) MDOut = 32'd0;
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus scoreboard of expected
// HI/LO results and busy lengths, and hand-written corner-case sequences.
module tb_md_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUControl;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          use_pre;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .MDUControl(MDUControl),
        .Start(Start),
        .A(A),
        .B(B),
        .Busy(Busy),
        .HI(HI),
        .LO(LO),
        .MDOut(MDOut)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, lets the edge sample them, then returns to idle inputs.
    task automatic applyStimulus(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic start);
        MDUControl = op;
        A          = a;
        B          = b;
        Start      = start;
        step();
        MDUControl = OP_NONE;
        Start      = 1'b0;
        A          = 32'd0;
        B          = 32'd0;
    endtask

    task automatic waitDone(string name, logic [31:0] hold_hi, logic [31:0] hold_lo, int already);
        exp_t e;
        int   n;
        n = already;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", name);
            return;
        end
        e = sb.pop_front();
        checkOutput({name, " hold HI"}, HI, hold_hi);
        checkOutput({name, " hold LO"}, LO, hold_lo);
        while (Busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        checkOutput({name, " busy cycles"}, 32'(n), 32'(e.cycles));
        checkOutput({name, " HI"}, HI, e.hi);
        checkOutput({name, " LO"}, LO, e.lo);
    endtask

    initial begin
        vecs[0]  = '{"mult",        OP_MULT,  32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{"multu",       OP_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,  32'd0,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{"divu 7/2",    OP_DIVU,  32'd7,        32'd2,        1'b0, 32'd0,  32'd0,        32'd1,        32'd3,        10};
        vecs[3]  = '{"div -7/2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'd0,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{"div 7/-2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'd0,  32'd0,        32'd1,        32'hFFFFFFFD, 10};
        vecs[5]  = '{"div ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,  32'd0,        32'd0,        32'h80000000, 10};
        vecs[6]  = '{"divu big",    OP_DIVU,  32'hFFFFFFFF, 32'h10,       1'b0, 32'd0,  32'd0,        32'hF,        32'h0FFFFFFF, 10};
        vecs[7]  = '{"maddu",       OP_MADDU, 32'd1,        32'd1,        1'b1, 32'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        5};
        vecs[8]  = '{"msub",        OP_MSUB,  32'd1,        32'd1,        1'b0, 32'd0,  32'd0,        32'd0,        32'hFFFFFFFF, 5};
        vecs[9]  = '{"div by zero", OP_DIV,   32'd9,        32'd0,        1'b1, 32'h11, 32'h22,       32'h11,       32'h22,       10};
        vecs[10] = '{"madd",        OP_MADD,  32'hFFFFFFFF, 32'd3,        1'b1, 32'd0,  32'd5,        32'd0,        32'd2,        5};
        vecs[11] = '{"msubu",       OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd0,  32'd0,        32'd1,        32'hFFFFFFFF, 5};
        vecs[12] = '{"mult min",    OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'd0,  32'd0,        32'h40000000, 32'd0,        5};

        reset      = 1'b1;
        Start      = 1'b0;
        MDUControl = OP_NONE;
        A          = 32'd0;
        B          = 32'd0;
        step();
        step();
        reset = 1'b0;
        checkOutput("reset Busy", 32'(Busy), 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        checkOutput("reset MDOut", MDOut, 32'd0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].use_pre) begin
                applyStimulus(OP_MTHI, vecs[i].pre_hi, 32'd0, 1'b0);
                applyStimulus(OP_MTLO, vecs[i].pre_lo, 32'd0, 1'b0);
                checkOutput({vecs[i].name, " preset HI"}, HI, vecs[i].pre_hi);
                checkOutput({vecs[i].name, " preset LO"}, LO, vecs[i].pre_lo);
            end
            prev_hi = HI;
            prev_lo = LO;
            sb.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cycles});
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            waitDone(vecs[i].name, prev_hi, prev_lo, 0);
        end

        // Inputs arriving mid-operation must not disturb it.
        prev_hi = HI;
        prev_lo = LO;
        sb.push_back('{32'd3, 32'h00040000, 5});
        applyStimulus(OP_MULT, 32'h00010000, 32'h00030004, 1'b1);
        step();
        applyStimulus(OP_MTLO, 32'h55, 32'd0, 1'b0);
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1);
        waitDone("ignored inputs", prev_hi, prev_lo, 3);

        MDUControl = OP_MFLO;
        #1;
        checkOutput("mflo MDOut", MDOut, 32'h00040000);
        MDUControl = OP_MFHI;
        #1;
        checkOutput("mfhi MDOut", MDOut, 32'd3);
        MDUControl = OP_MULT;
        #1;
        checkOutput("non-mf MDOut", MDOut, 32'd0);

        applyStimulus(OP_MULT, 32'd5, 32'd5, 1'b0);
        checkOutput("no start Busy", 32'(Busy), 32'd0);
        applyStimulus(OP_NONE, 32'd5, 32'd5, 1'b1);
        checkOutput("start none Busy", 32'(Busy), 32'd0);
        checkOutput("no start HI", HI, 32'd3);
        checkOutput("no start LO", LO, 32'h00040000);

        // Reset during the third busy cycle of a divide aborts it.
        applyStimulus(OP_MTHI, 32'h77, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h88, 32'd0, 1'b0);
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1);
        checkOutput("abort busy before reset", 32'(Busy), 32'd1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort Busy", 32'(Busy), 32'd0);
        checkOutput("abort HI", HI, 32'd0);
        checkOutput("abort LO", LO, 32'd0);
        repeat (15) step();
        checkOutput("abort late Busy", 32'(Busy), 32'd0);
        checkOutput("abort late HI", HI, 32'd0);
        checkOutput("abort late LO", LO, 32'd0);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline.
- Executes the HI/LO-class operations issued by the instruction decoder's MDUControl code: mult, multu, div, divu, madd, maddu, msub, msubu, mthi, mtlo, mfhi, mflo.
- Models multi-cycle latency with a Busy flag. The hazard unit stalls any md/mf/mt instruction in D while Start|Busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- MDUControl  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
- Start  input  1  E-stage instruction is a valid md op (codes 1-4, 9-12); 1-cycle pulse.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Busy  output  1  registered; operation in progress.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDOut  output  32  combinational: HI if MFHI, LO if MFLO, else 0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high: on posedge clk with reset=1, HI=0, LO=0, Busy=0, counter=0, pending result cleared.
- Reset mid-operation aborts the op; nothing is committed.
- States: IDLE and RUN.
- IDLE: Busy=0.
  - Start=1 with an md code latches A, B and the op, computes or holds the 64-bit pending result {pHI,pLO}, loads counter = MULT_CYCLES or DIV_CYCLES, and goes to RUN.
  - Busy=1 from the next cycle.
- RUN: Busy=1; counter decrements each cycle.
  - At the cycle where counter==1: {HI,LO} <= {pHI,pLO}, Busy <= 0, go to IDLE.
- Timing: Start sampled at edge t → Busy high for edges t+1 .. t+N → new HI/LO visible after edge t+N, with Busy=0 in the same cycle.
- Start while Busy=1: ignored, no restart; the hazard unit guarantees this never happens.
- Arithmetic, all 64-bit modulo 2^64:
  - mult: {HI,LO} = signed A × signed B.
  - multu: {HI,LO} = unsigned A × unsigned B.
  - madd / maddu: {HI,LO} + (A×B), signed / unsigned product.
  - msub / msubu: {HI,LO} − (A×B).
  - The accumulate operand is the HI/LO value at the Start edge.
- Division:
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero (B==0): full DIV_CYCLES of Busy, then HI/LO unchanged.
- mthi / mtlo (Start=0): HI<=A or LO<=A at the next edge when Busy=0; ignored while Busy=1.
- mfhi / mflo: MDOut reflects the registered HI/LO, never the pending result.
- MDUControl=0 or Start=0 with an md code: no state change.
- The hazard unit's stall term is Start|Busy. The unit itself exports only Busy.

Test Plan:
- mult: reset, then Start, MULT, A=0xFFFFFFFF, B=2 → Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, Busy=0. HI/LO read 0 while Busy.
- divu / div: divu A=7, B=2 → after 10 busy cycles HI=1, LO=3. div A=-7, B=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- Divide by zero and overflow: mthi 0x11, mtlo 0x22, then div B=0 → Busy for 10 cycles, HI=0x11, LO=0x22. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0. Then msub A=1, B=1 → HI=0, LO=0xFFFFFFFF.
- Ignored inputs and mf path: during mult Busy, apply mtlo 0x55 and a second Start div → both ignored; final HI/LO equal the mult result. mflo then gives MDOut=LO combinationally.
- Reset mid-op: reset asserted at busy cycle 3 of a div → next cycle Busy=0, HI=LO=0; no later commit.
